ifetch_queue: RTL

Parametrised successor to the single-slot instruction fetcher. It keeps a DEPTH-entry instruction queue between the icache and the decoder, with one outstanding icache request at a time. JAL is resolved locally, the fetch stream holds on JALR, and non-jump instructions take the branch predictor's next PC. Stale icache responses arriving after a ROB flush are discarded.

---
 rtl/ifetch_queue_pkg.sv | 22 ++
 rtl/ifetch_fifo.sv | 71 +++++++
 rtl/ifetch_queue.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared constants for the instruction fetch queue.
//   OPC_JAL / OPC_JALR : RV32 opcodes resolved or held by the fetcher
//   fetch_state_e      : fetch sequencer states
//   jal_imm            : reassembles the JAL offset from instruction bits [31:12]
package ifetch_queue_pkg;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_JALR_HOLD,
    ST_DISCARD
  } fetch_state_e;

  // hi = ins[31:12]; result = {ins[31], ins[19:12], ins[20], ins[30:21], 0}
  function automatic logic [20:0] jal_imm(input logic [19:0] hi);
    return {hi[19], hi[7:0], hi[8], hi[18:9], 1'b0};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous DEPTH x WIDTH FIFO holding fetched instructions.
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   push, din        : write din at the tail
//   pop              : drop the head entry
//   flush            : empty the queue (wins over push/pop)
//   dout             : head entry
//   count            : number of valid entries
//   full, empty      : occupancy flags
module ifetch_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push at full is accepted only when the same-cycle pop frees a slot.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        cnt <= cnt + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetcher with a DEPTH-entry queue between icache and decoder.
// One icache request outstanding at a time; JAL resolved locally, JALR holds
// the stream until its target arrives, others follow the branch predictor.
//   clk_in, rst_n_in, rdy_in           : clock, async active-low reset, stall (low)
//   fetch_valid, fetch_pc              : icache request
//   icache_valid, icache_ins           : icache response pulse
//   dec_valid/ready, dec_ins/pc/pred_pc: queue head towards the decoder
//   bp_ins, bp_pc, bp_pred_pc          : combinational predictor lookup
//   br_reset, br_pc                    : ROB mispredict flush
//   jalr_clear, jalr_pc                : resolved JALR target
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            rdy_in,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  input  logic            icache_valid,
  input  logic [31:0]     icache_ins,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [31:0]     dec_ins,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_pred_pc,
  output logic [31:0]     bp_ins,
  output logic [XLEN-1:0] bp_pc,
  input  logic [XLEN-1:0] bp_pred_pc,
  input  logic            br_reset,
  input  logic [XLEN-1:0] br_pc,
  input  logic            jalr_clear,
  input  logic [XLEN-1:0] jalr_pc
);

  localparam int unsigned EW    = 32 + 2 * XLEN;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e     state, state_nxt;
  logic [XLEN-1:0]  pc, pc_nxt;
  logic             fv_nxt;
  logic [XLEN-1:0]  fpc_nxt;
  logic             push_req;
  logic [XLEN-1:0]  pred;
  logic [20:0]      imm21;
  logic [XLEN-1:0]  jal_off;
  logic [6:0]       opcode;

  logic [EW-1:0]    head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;

  assign bp_ins  = icache_ins;
  assign bp_pc   = pc;
  assign opcode  = icache_ins[6:0];
  assign imm21   = jal_imm(icache_ins[31:12]);
  assign jal_off = {{(XLEN-21){imm21[20]}}, imm21};

  always_comb begin
    pred = bp_pred_pc;
    if (opcode == OPC_JAL) begin
      pred = pc + jal_off;
    end else if (opcode == OPC_JALR) begin
      pred = pc + XLEN'(4);
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    fv_nxt    = fetch_valid;
    fpc_nxt   = fetch_pc;
    push_req  = 1'b0;
    if (br_reset) begin
      pc_nxt = br_pc & ~XLEN'(1);
      fv_nxt = 1'b0;
      // An unanswered request still has a response in flight; swallow it.
      state_nxt = (state == ST_WAIT && !icache_valid) ? ST_DISCARD : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_count < CNT_W'(DEPTH)) begin
            fv_nxt    = 1'b1;
            fpc_nxt   = pc;
            state_nxt = ST_WAIT;
          end else begin
            fv_nxt = 1'b0;
          end
        end
        ST_WAIT: begin
          if (icache_valid) begin
            push_req = 1'b1;
            fv_nxt   = 1'b0;
            if (opcode == OPC_JALR) begin
              state_nxt = ST_JALR_HOLD;
            end else begin
              pc_nxt    = pred;
              state_nxt = ST_IDLE;
            end
          end
        end
        ST_JALR_HOLD: begin
          fv_nxt = 1'b0;
          if (jalr_clear) begin
            pc_nxt    = jalr_pc;
            state_nxt = ST_IDLE;
          end
        end
        ST_DISCARD: begin
          fv_nxt = 1'b0;
          if (icache_valid) begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      fetch_pc    <= '0;
    end else if (rdy_in) begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      fetch_valid <= fv_nxt;
      fetch_pc    <= fpc_nxt;
    end
  end

  assign fifo_flush = rdy_in && br_reset;
  assign fifo_pop   = rdy_in && !br_reset && dec_valid && dec_ready;
  assign fifo_push  = rdy_in && push_req && (!fifo_full || fifo_pop);

  ifetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .din      ({icache_ins, pc, pred}),
    .dout     (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign dec_valid   = !fifo_empty;
  assign dec_ins     = head[EW-1 -: 32];
  assign dec_pc      = head[2*XLEN-1 -: XLEN];
  assign dec_pred_pc = head[XLEN-1:0];

endmodule
